uart_tx_queue: RTL

Byte queue and launch controller upstream of the UART transmit FSM. Buffers bytes written by the CPU through the UART CSR write path. Presents one byte at a time on a held data bus. Issues a single-cycle `send_data` request whenever the transmitter reports idle. Also reports occupancy, overflow and per-frame completion back to the CSR block.

---
 rtl/uart_tx_queue_pkg.sv | 13 +
 rtl/uart_tx_queue_if.sv | 34 +++
 rtl/uart_tx_queue_sync_fifo.sv | 76 +++++++
 rtl/uart_tx_queue.sv | 101 ++++++++++
 4 files changed

// File: rtl/uart_tx_queue_pkg.sv
// rtl/uart_tx_queue_pkg.sv - shared types and constants for the UART transmit queue
package uart_tx_queue_pkg;

  localparam int UART_TXQ_DEPTH = 8;

  typedef enum logic [1:0] {
    TXQ_IDLE_S        = 2'd0,
    TXQ_SEND_S        = 2'd1,
    TXQ_WAIT_ACCEPT_S = 2'd2,
    TXQ_WAIT_DONE_S   = 2'd3
  } txq_state_e;

endpackage

// File: rtl/uart_tx_queue_if.sv
// rtl/uart_tx_queue_if.sv - CSR/transmitter-facing signal bundle of the transmit queue
interface uart_tx_queue_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              flush;
  logic              clr_overflow;
  logic              tx_enable;
  logic              tx_data_ready;
  logic              data_sent;
  logic [DATA_W-1:0] tx_data;
  logic              send_data;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              byte_done;
  logic              busy;

  modport slave (
    input  wr_en, wr_data, flush, clr_overflow, tx_enable, tx_data_ready, data_sent,
    output tx_data, send_data, full, empty, count, overflow, byte_done, busy
  );

  modport master (
    output wr_en, wr_data, flush, clr_overflow, tx_enable, tx_data_ready, data_sent,
    input  tx_data, send_data, full, empty, count, overflow, byte_done, busy
  );

endinterface

// File: rtl/uart_tx_queue_sync_fifo.sv
// rtl/uart_tx_queue_sync_fifo.sv - circular-buffer byte FIFO with explicit occupancy count
module uart_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              drop_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full, empty;
  logic              push_ok, pop_ok;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // A full queue drops the write even when a pop frees a slot this cycle.
  assign push_ok = push_i && !full && !flush_i;
  assign pop_ok  = pop_i && !empty && !flush_i;
  assign drop_o  = push_i && full && !flush_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + PTR_W'(1);
      if (pop_ok)  rptr_d = rptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;
  assign full_o  = full;
  assign empty_o = empty;

endmodule

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - byte queue and launch controller in front of the UART transmit FSM
module uart_tx_queue
  import uart_tx_queue_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = UART_TXQ_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_queue_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [1:0] ST_IDLE        = 2'(TXQ_IDLE_S);
  localparam logic [1:0] ST_SEND        = 2'(TXQ_SEND_S);
  localparam logic [1:0] ST_WAIT_ACCEPT = 2'(TXQ_WAIT_ACCEPT_S);
  localparam logic [1:0] ST_WAIT_DONE   = 2'(TXQ_WAIT_DONE_S);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              overflow_q, overflow_d;
  logic              data_sent_q;
  logic              byte_done_q;

  logic [DATA_W-1:0] fifo_rdata;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty, fifo_drop;
  logic              launch;

  uart_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (bus.wr_en),
    .pop_i   (launch),
    .flush_i (bus.flush),
    .wdata_i (bus.wr_data),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

  // tx_enable gates only new launches; a frame already under way runs to completion.
  assign launch = (state_q == ST_IDLE) && !fifo_empty && bus.tx_enable
                  && bus.tx_data_ready && !bus.flush;

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          tx_data_d = fifo_rdata;
          state_d   = ST_SEND;
        end
      end
      ST_SEND:        state_d = ST_WAIT_ACCEPT;
      ST_WAIT_ACCEPT: if (!bus.tx_data_ready) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE:   if (bus.tx_data_ready) state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
  end

  // A drop in the same cycle as clr_overflow keeps the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (fifo_drop)             overflow_d = 1'b1;
    else if (bus.clr_overflow) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tx_data_q   <= '0;
      overflow_q  <= 1'b0;
      data_sent_q <= 1'b0;
      byte_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_data_q   <= tx_data_d;
      overflow_q  <= overflow_d;
      data_sent_q <= bus.data_sent;
      byte_done_q <= bus.data_sent && !data_sent_q;
    end
  end

  assign bus.tx_data   = tx_data_q;
  assign bus.send_data = (state_q == ST_SEND);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.full      = fifo_full;
  assign bus.empty     = fifo_empty;
  assign bus.count     = fifo_count;
  assign bus.overflow  = overflow_q;
  assign bus.byte_done = byte_done_q;

endmodule
